// File: rtl/lemmings_pkg.sv
// Shared types and helpers for the lemming terrain model and its benches.
package lemmings_pkg;

    typedef enum logic {RUN, DEAD} world_state_e;

    // Walker FSM state encoding, for benches that model the walker side.
    localparam logic [2:0] LEFT   = 3'd0;
    localparam logic [2:0] RIGHT  = 3'd1;
    localparam logic [2:0] FALL_L = 3'd2;
    localparam logic [2:0] DIG_L  = 3'd3;
    localparam logic [2:0] FALL_R = 3'd4;
    localparam logic [2:0] DIG_R  = 3'd5;

    function automatic int unsigned cell_idx(input int unsigned r, input int unsigned c,
                                             input int unsigned n);
        return r * n + c;
    endfunction

endpackage

// File: rtl/lemmings_terrain.sv
// R x N solid-cell map with synchronous load, single-cell clear and neighbour taps.
module lemmings_terrain #(
    parameter int unsigned N  = 8,
    parameter int unsigned R  = 4,
    parameter int unsigned XW = 3,
    parameter int unsigned YW = 2
) (
    input  logic            clk,
    input  logic            load,
    input  logic [R*N-1:0]  init_map,
    input  logic            clr,
    input  logic [XW-1:0]   clr_x,
    input  logic [YW-1:0]   clr_y,
    input  logic [XW-1:0]   pos_x,
    input  logic [YW-1:0]   pos_y,
    output logic            solid_below,
    output logic            solid_left,
    output logic            solid_right
);

    localparam logic [XW-1:0] LAST_COL = XW'(N - 1);
    localparam logic [YW-1:0] LAST_ROW = YW'(R - 1);

    // Packed so that bit r*N+c of init_map lands on map_q[r][c].
    logic [R-1:0][N-1:0] map_q;

    always_ff @(posedge clk) begin
        if (load) begin
            map_q <= init_map;
        end else if (clr) begin
            map_q[clr_y][clr_x] <= 1'b0;
        end
    end

    // Floor and side walls read as solid.
    always_comb begin
        solid_below = 1'b1;
        solid_left  = 1'b1;
        solid_right = 1'b1;
        if (pos_y != LAST_ROW) begin
            solid_below = map_q[pos_y + 1'b1][pos_x];
        end
        if (pos_x != '0) begin
            solid_left = map_q[pos_y][pos_x - 1'b1];
        end
        if (pos_x != LAST_COL) begin
            solid_right = map_q[pos_y][pos_x + 1'b1];
        end
    end

endmodule

// File: rtl/lemmings_world.sv
// Environment side of the lemming walker: position, falls, digging and fatal landings.
module lemmings_world
    import lemmings_pkg::*;
#(
    parameter int unsigned N          = 8,
    parameter int unsigned R          = 4,
    parameter int unsigned START_X    = 0,
    parameter int unsigned DIG_CYCLES = 3,
    parameter int unsigned SPLAT_FALL = 3,
    parameter int unsigned XW         = 3,
    parameter int unsigned YW         = 2
) (
    input  logic            clk,
    input  logic            resetn,
    input  logic [R*N-1:0]  terrain_init,
    input  logic            walk_left,
    input  logic            walk_right,
    input  logic            aaah,
    input  logic            digging,
    output logic            ground,
    output logic            bump_left,
    output logic            bump_right,
    output logic [XW-1:0]   pos_x,
    output logic [YW-1:0]   pos_y,
    output logic            splat,
    output logic            protocol_err
);

    localparam int unsigned CELLS = R * N;
    localparam int unsigned DW    = $clog2(DIG_CYCLES + 1);
    localparam int unsigned FW    = $clog2(SPLAT_FALL + 1);
    localparam logic [YW-1:0]    LAST_ROW   = YW'(R - 1);
    localparam logic [DW-1:0]    DIG_LAST   = DW'(DIG_CYCLES - 1);
    localparam logic [FW-1:0]    FALL_LIMIT = FW'(SPLAT_FALL);
    localparam logic [CELLS-1:0] START_MASK = ~(CELLS'(1) << cell_idx(0, START_X, N));

    world_state_e  state_q, state_d;
    logic [XW-1:0] pos_x_q, pos_x_d;
    logic [YW-1:0] pos_y_q, pos_y_d;
    logic [DW-1:0] dig_cnt_q, dig_cnt_d;
    logic [FW-1:0] fall_cnt_q, fall_cnt_d;
    logic          splat_q, splat_d;
    logic          perr_q, perr_d;
    logic          dig_clr;
    logic          one_hot;
    logic          solid_below, solid_left, solid_right;
    logic [YW-1:0] dig_row;

    assign dig_row = pos_y_q + 1'b1;

    lemmings_terrain #(
        .N  (N),
        .R  (R),
        .XW (XW),
        .YW (YW)
    ) u_terrain (
        .clk         (clk),
        .load        (!resetn),
        .init_map    (terrain_init & START_MASK),
        .clr         (dig_clr),
        .clr_x       (pos_x_q),
        .clr_y       (dig_row),
        .pos_x       (pos_x_q),
        .pos_y       (pos_y_q),
        .solid_below (solid_below),
        .solid_left  (solid_left),
        .solid_right (solid_right)
    );

    assign ground       = solid_below;
    assign bump_left    = walk_left & solid_left;
    assign bump_right   = walk_right & solid_right;
    assign pos_x        = pos_x_q;
    assign pos_y        = pos_y_q;
    assign splat        = splat_q;
    assign protocol_err = perr_q;

    always_comb begin
        one_hot    = $onehot({walk_left, walk_right, aaah, digging});
        state_d    = state_q;
        pos_x_d    = pos_x_q;
        pos_y_d    = pos_y_q;
        dig_cnt_d  = dig_cnt_q;
        fall_cnt_d = fall_cnt_q;
        splat_d    = splat_q;
        perr_d     = perr_q;
        dig_clr    = 1'b0;

        if (state_q == RUN) begin
            if (!one_hot) begin
                perr_d = 1'b1;
            end else begin
                if (!digging) begin
                    dig_cnt_d = '0;
                end
                if (walk_left && !bump_left) begin
                    pos_x_d = pos_x_q - 1'b1;
                end
                if (walk_right && !bump_right) begin
                    pos_x_d = pos_x_q + 1'b1;
                end
                if (aaah) begin
                    if (!ground) begin
                        pos_y_d = pos_y_q + 1'b1;
                        if (fall_cnt_q != FALL_LIMIT) begin
                            fall_cnt_d = fall_cnt_q + 1'b1;
                        end
                    end else if (fall_cnt_q >= FALL_LIMIT) begin
                        splat_d = 1'b1;
                        state_d = DEAD;
                    end else begin
                        fall_cnt_d = '0;
                    end
                end
                // The floor row has nothing diggable below it.
                if (digging) begin
                    if (ground && pos_y_q != LAST_ROW) begin
                        if (dig_cnt_q == DIG_LAST) begin
                            dig_clr   = 1'b1;
                            dig_cnt_d = '0;
                        end else begin
                            dig_cnt_d = dig_cnt_q + 1'b1;
                        end
                    end else begin
                        dig_cnt_d = '0;
                    end
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            state_q    <= RUN;
            pos_x_q    <= XW'(START_X);
            pos_y_q    <= '0;
            dig_cnt_q  <= '0;
            fall_cnt_q <= '0;
            splat_q    <= 1'b0;
            perr_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            pos_x_q    <= pos_x_d;
            pos_y_q    <= pos_y_d;
            dig_cnt_q  <= dig_cnt_d;
            fall_cnt_q <= fall_cnt_d;
            splat_q    <= splat_d;
            perr_q     <= perr_d;
        end
    end

endmodule

// File: tb/tb_lemmings_world.sv
// Directed terrain scenarios plus randomized walker traffic against a behavioural grid model.
module tb_lemmings_world;
    import lemmings_pkg::*;

    localparam int unsigned N          = 8;
    localparam int unsigned R          = 4;
    localparam int unsigned START_X    = 0;
    localparam int unsigned DIG_CYCLES = 3;
    localparam int unsigned SPLAT_FALL = 3;
    localparam int unsigned XW         = 3;
    localparam int unsigned YW         = 2;

    localparam logic [3:0] W_LEFT  = 4'b1000;
    localparam logic [3:0] W_RIGHT = 4'b0100;
    localparam logic [3:0] W_AAAH  = 4'b0010;
    localparam logic [3:0] W_DIG   = 4'b0001;

    logic           clk = 1'b0;
    logic           resetn;
    logic [R*N-1:0] terrain_init;
    logic           walk_left, walk_right, aaah, digging;
    logic           ground, bump_left, bump_right, splat, protocol_err;
    logic [XW-1:0]  pos_x;
    logic [YW-1:0]  pos_y;

    always #5 clk = ~clk;

    lemmings_world #(
        .N          (N),
        .R          (R),
        .START_X    (START_X),
        .DIG_CYCLES (DIG_CYCLES),
        .SPLAT_FALL (SPLAT_FALL),
        .XW         (XW),
        .YW         (YW)
    ) dut (
        .clk          (clk),
        .resetn       (resetn),
        .terrain_init (terrain_init),
        .walk_left    (walk_left),
        .walk_right   (walk_right),
        .aaah         (aaah),
        .digging      (digging),
        .ground       (ground),
        .bump_left    (bump_left),
        .bump_right   (bump_right),
        .pos_x        (pos_x),
        .pos_y        (pos_y),
        .splat        (splat),
        .protocol_err (protocol_err)
    );

    int n_tests = 0;
    int n_fail  = 0;

    // Reference world: plain grid of solid flags plus integer position and counters.
    bit m[R][N];
    int mx, my, mdig, mfall;
    bit msplat, mperr, mdead;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Anything outside the grid (floor, side walls) is solid.
    function automatic bit solid(input int r, input int c);
        if (r >= int'(R)) return 1'b1;
        if (c < 0 || c >= int'(N)) return 1'b1;
        return m[r][c];
    endfunction

    task automatic model_step(input logic [3:0] w);
        int cnt;
        bit g;
        cnt = int'(w[0]) + int'(w[1]) + int'(w[2]) + int'(w[3]);
        if (mdead) return;
        if (cnt != 1) begin
            mperr = 1'b1;
            return;
        end
        g = solid(my + 1, mx);
        if (!w[0]) mdig = 0;
        if (w[3] && !solid(my, mx - 1)) mx--;
        if (w[2] && !solid(my, mx + 1)) mx++;
        if (w[1]) begin
            if (!g) begin
                my++;
                mfall = (mfall + 1 > int'(SPLAT_FALL)) ? int'(SPLAT_FALL) : mfall + 1;
            end else if (mfall >= int'(SPLAT_FALL)) begin
                msplat = 1'b1;
                mdead  = 1'b1;
            end else begin
                mfall = 0;
            end
        end
        if (w[0]) begin
            if (g && my != int'(R) - 1) begin
                mdig++;
                if (mdig == int'(DIG_CYCLES)) begin
                    m[my + 1][mx] = 1'b0;
                    mdig = 0;
                end
            end else begin
                mdig = 0;
            end
        end
    endtask

    task automatic do_reset(input logic [R*N-1:0] init);
        @(negedge clk);
        resetn       = 1'b0;
        terrain_init = init;
        {walk_left, walk_right, aaah, digging} = 4'b0000;
        @(posedge clk);
        for (int r = 0; r < int'(R); r++)
            for (int c = 0; c < int'(N); c++)
                m[r][c] = init[cell_idx(r, c, N)];
        m[0][START_X] = 1'b0;
        mx = START_X; my = 0; mdig = 0; mfall = 0;
        msplat = 1'b0; mperr = 1'b0; mdead = 1'b0;
    endtask

    // Drive one walker output vector for one cycle, checking the pre-edge outputs.
    task automatic step(input logic [3:0] w);
        @(negedge clk);
        resetn = 1'b1;
        {walk_left, walk_right, aaah, digging} = w;
        #1;
        check_eq("ground", ground, solid(my + 1, mx));
        check_eq("bump_left", bump_left, w[3] & solid(my, mx - 1));
        check_eq("bump_right", bump_right, w[2] & solid(my, mx + 1));
        check_eq("pos_x", pos_x, mx);
        check_eq("pos_y", pos_y, my);
        check_eq("splat", splat, msplat);
        check_eq("protocol_err", protocol_err, mperr);
        @(posedge clk);
        model_step(w);
    endtask

    task automatic repeat_step(input logic [3:0] w, input int n);
        for (int i = 0; i < n; i++) step(w);
    endtask

    initial begin
        logic [3:0]  w;
        logic [31:0] rmap;
        resetn = 1'b0;
        terrain_init = '0;
        {walk_left, walk_right, aaah, digging} = 4'b0000;

        // Walls: bump at x=0 going left, walk to x=7 and bump there.
        do_reset(32'hFF00_0000);
        step(W_LEFT);
        repeat_step(W_RIGHT, 9);

        // Short fall through a gap at col 3, safe landing after two rows.
        do_reset(32'hFFF7_F700);
        repeat_step(W_RIGHT, 3);
        repeat_step(W_AAAH, 3);
        repeat_step(W_RIGHT, 2);

        // Dig through row 1 at x=2, then fall.
        do_reset(32'h0000_FF00);
        repeat_step(W_RIGHT, 2);
        repeat_step(W_DIG, 3);
        repeat_step(W_AAAH, 3);

        // Fatal fall from row 0 to the floor, then frozen while dead.
        do_reset(32'h0000_0F00);
        repeat_step(W_RIGHT, 4);
        repeat_step(W_AAAH, 4);
        step(W_LEFT);
        step(W_RIGHT);
        step(4'b1100);
        step(W_DIG);

        // Protocol error is sticky; reset clears it.
        do_reset(32'hFF00_0000);
        step(4'b1100);
        step(W_RIGHT);
        step(4'b0000);
        step(W_RIGHT);

        // Dug cell comes back after reset.
        do_reset(32'h0000_FF00);
        repeat_step(W_RIGHT, 2);
        repeat_step(W_DIG, 3);
        step(W_LEFT);
        do_reset(32'h0000_FF00);
        repeat_step(W_RIGHT, 2);
        step(W_DIG);

        // Dig down two layers, then dig on the floor for a long time.
        do_reset(32'h00FF_FF00);
        repeat_step(W_DIG, 3);
        repeat_step(W_AAAH, 2);
        repeat_step(W_DIG, 3);
        repeat_step(W_AAAH, 3);
        repeat_step(W_DIG, 10);
        step(W_RIGHT);

        // Random terrain and walker traffic, with periodic resets.
        for (int k = 0; k < 600; k++) begin
            if (k % 75 == 0) begin
                rmap = $urandom & $urandom;
                do_reset(rmap);
            end
            if ($urandom_range(0, 29) == 0) begin
                w = 4'($urandom_range(0, 15));
            end else if (!solid(my + 1, mx) && $urandom_range(0, 9) < 7) begin
                w = W_AAAH;
            end else begin
                w = 4'b0001 << $urandom_range(0, 3);
            end
            step(w);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
